// File: rtl/debug_mem_dump.sv
// Debug memory dump engine: walks the data RAM debug port from word 0 to
// N_WORDS-1 and streams each word MSB byte first on a valid/ready byte bus.
module debug_mem_dump #(
  parameter int unsigned LEN     = 32,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_ADDR = 11,
  parameter int unsigned N_WORDS = 2048
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_mem_en,
  input  logic [LEN-1:0]     i_mem_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned CNT_W     = 2;
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(LEN / NB_BYTE - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]     shift_q, shift_d;
  logic               mem_en_q, mem_en_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, datapath and next-output decode; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shift_d = i_mem_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && i_tx_ready) begin
          if (cnt_q != LAST_BYTE) begin
            shift_d = shift_q << NB_BYTE;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + NB_ADDR'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_en_d   = (state_d == S_FETCH);
    tx_valid_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers; reset aborts any dump in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      mem_en_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mem_en_q   <= mem_en_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_en   = mem_en_q;
  assign o_tx_data  = shift_q[LEN-1 -: NB_BYTE];
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_debug_mem_dump.sv
// Bench for debug_mem_dump: RAM model, random backpressure, byte scoreboard.
module tb_debug_mem_dump;

  localparam int unsigned LEN     = 32;
  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned NB_ADDR = 11;
  localparam int unsigned N_WORDS = 2048;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [NB_ADDR-1:0] mem_addr;
  logic               mem_en;
  logic [LEN-1:0]     mem_data = '0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic               busy;
  logic               done;

  logic [LEN-1:0] ram [N_WORDS];
  logic [7:0]     exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepted = 0;
  int last_hs_cyc = -10;
  int ready_pct = 100;
  int stall_cnt = 0;
  int max_addr = 0;
  bit expect_done = 1'b0;

  debug_mem_dump #(
    .LEN(LEN), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR), .N_WORDS(N_WORDS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .o_mem_addr(mem_addr),
    .o_mem_en(mem_en),
    .i_mem_data(mem_data),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_busy(busy),
    .o_done(done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data appears one cycle after the enable.
  always @(posedge clk) if (mem_en) mem_data <= ram[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Transmitter readiness: forced stalls first, otherwise random with ready_pct.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      tx_ready = 1'b0;
      stall_cnt--;
    end else begin
      tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: pops expected bytes on each handshake, checks holding and done.
  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(tx_valid), 32'd1);
          chk("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            chk("byte", 32'(tx_data), 32'(exp_b));
          end
          accepted++;
          last_hs_cyc = cyc;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (mem_en && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (done) begin
          chk("done_expected", 32'(expect_done), 32'd1);
          chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
          chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
          expect_done = 1'b0;
        end
      end
    end
  end

  // Expected stream for a full dump: every word, most significant byte first.
  task automatic push_dump();
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < int'(N_WORDS); i++) begin
      w = ram[i];
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
    end
    accepted    = 0;
    expect_done = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start latency: fetch of word 0 next cycle, first byte valid two cycles later.
  task automatic start_and_check_timing(input logic [7:0] first_byte);
    pulse_start();
    @(negedge clk);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd0);
    chk("t1_valid", 32'(tx_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_mem_en", 32'(mem_en), 32'd0);
    chk("t2_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t3_valid", 32'(tx_valid), 32'd1);
    chk("t3_first_byte", 32'(tx_data), 32'(first_byte));
  endtask

  task automatic wait_done(input int budget, input int inject_at);
    bit seen = 1'b0;
    bit inj = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (inject_at >= 0 && accepted == inject_at && !inj) begin
        inj = 1'b1;
        pulse_start();
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
    chk("byte_total", 32'(accepted), 32'(4 * N_WORDS));
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N_WORDS); i++) ram[i] = $urandom;
  endtask

  initial begin
    bit reached;
    fill_random();
    ram[0] = 32'hDEADBEEF;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Dump A: ready high, with a five-cycle stall on the second byte.
    ready_pct = 100;
    push_dump();
    start_and_check_timing(8'hDE);
    stall_cnt = 5;
    @(negedge clk);
    chk("stall_valid", 32'(tx_valid), 32'd1);
    chk("stall_data", 32'(tx_data), 32'hAD);
    chk("stall_ready", 32'(tx_ready), 32'd0);
    wait_done(20000, -1);

    // Dump B: RAM[i]=i, random backpressure, stray start mid word 1.
    for (int i = 0; i < int'(N_WORDS); i++) ram[i] = 32'(i);
    ready_pct = 60;
    max_addr = 0;
    push_dump();
    pulse_start();
    wait_done(30000, 6);
    chk("max_addr", 32'(max_addr), 32'h7FF);

    // Dump C: asynchronous reset while word 1 is being sent.
    fill_random();
    ready_pct = 80;
    push_dump();
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (accepted == 5) reached = 1'b1;
    end
    chk("abort_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_data", 32'(tx_data), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    expect_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_abort_quiet", 32'({done, busy, tx_valid}), 32'd0);
    end

    // Dump D: fresh start after abort begins again from address 0.
    ready_pct = 75;
    push_dump();
    start_and_check_timing(ram[0][31:24]);
    wait_done(30000, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
